// File: rtl/hypercorex_fetch_pkg.sv
// Shared types and defaults for the item-memory stream fetchers.
package hypercorex_fetch_pkg;

  localparam int unsigned DefaultSlotWidth = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/mux.sv
// Generic N-way selector over a flat vector of equally sized fields.
module mux #(
  parameter int unsigned NumSel    = 2,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned SelWidth  = (NumSel > 1) ? $clog2(NumSel) : 1
) (
  input  logic [NumSel*DataWidth-1:0] data_i,
  input  logic [SelWidth-1:0]         sel_i,
  output logic [DataWidth-1:0]        data_o
);

  assign data_o = data_i[sel_i*DataWidth +: DataWidth];

endmodule

// File: rtl/im_stream_fetcher.sv
// Reads packed item indices from data memory one word at a time and streams
// them over a valid/ready port; single outstanding read, no prefetch.
module im_stream_fetcher
  import hypercorex_fetch_pkg::*;
#(
  parameter int unsigned MemAddrWidth  = 32,
  parameter int unsigned MemDataWidth  = 64,
  parameter int unsigned SlotWidth     = DefaultSlotWidth,
  parameter int unsigned ImAddrWidth   = 10,
  parameter int unsigned NumItemsWidth = 16,
  parameter int unsigned SlotsPerWord  = MemDataWidth / SlotWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     start_i,
  input  logic [MemAddrWidth-1:0]  cfg_base_addr_i,
  input  logic [NumItemsWidth-1:0] cfg_num_items_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     mem_req_o,
  output logic [MemAddrWidth-1:0]  mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [MemDataWidth-1:0]  mem_rdata_i,
  output logic [ImAddrWidth-1:0]   lowdim_data_o,
  output logic                     lowdim_valid_o,
  input  logic                     lowdim_ready_i
);

  localparam int unsigned SlotIdxWidth = (SlotsPerWord > 1) ? $clog2(SlotsPerWord) : 1;
  localparam logic [MemAddrWidth-1:0] WordBytes = MemAddrWidth'(MemDataWidth / 8);
  localparam logic [SlotIdxWidth-1:0] LastSlot  = SlotIdxWidth'(SlotsPerWord - 1);

  fetch_state_t             state;
  logic [NumItemsWidth-1:0] num_items;
  logic [NumItemsWidth-1:0] item_cnt;
  logic [SlotIdxWidth-1:0]  slot_idx;
  logic [MemDataWidth-1:0]  word_buf;
  logic [SlotWidth-1:0]     slot_data;
  logic                     handshake;
  logic                     last_item;

  assign handshake = lowdim_valid_o & lowdim_ready_i;
  assign last_item = (item_cnt + 1'b1) == num_items;

  mux #(
    .NumSel   (SlotsPerWord),
    .DataWidth(SlotWidth),
    .SelWidth (SlotIdxWidth)
  ) i_slot_mux (
    .data_i(word_buf),
    .sel_i (slot_idx),
    .data_o(slot_data)
  );

  assign lowdim_data_o = slot_data[ImAddrWidth-1:0];

  // Outputs are registered alongside the state so they change only on transitions.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state          <= IDLE;
      num_items      <= '0;
      item_cnt       <= '0;
      slot_idx       <= '0;
      word_buf       <= '0;
      mem_addr_o     <= '0;
      mem_req_o      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      lowdim_valid_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            num_items  <= cfg_num_items_i;
            mem_addr_o <= cfg_base_addr_i;
            item_cnt   <= '0;
            slot_idx   <= '0;
            busy_o     <= 1'b1;
            if (cfg_num_items_i == '0) begin
              state <= DONE;
            end else begin
              state     <= REQ;
              mem_req_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            word_buf       <= mem_rdata_i;
            lowdim_valid_o <= 1'b1;
            state          <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            item_cnt <= item_cnt + 1'b1;
            slot_idx <= slot_idx + 1'b1;
            if (last_item) begin
              lowdim_valid_o <= 1'b0;
              state          <= DONE;
            end else if (slot_idx == LastSlot) begin
              lowdim_valid_o <= 1'b0;
              slot_idx       <= '0;
              mem_addr_o     <= mem_addr_o + WordBytes;
              mem_req_o      <= 1'b1;
              state          <= REQ;
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_stream_fetcher.sv
// Scoreboard bench for im_stream_fetcher: directed jobs against a small memory model.
module tb_im_stream_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_num = '0;
  logic        busy, done, req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;
  logic [9:0]  ldata;
  logic        lvalid;
  logic        lready = 1'b1;

  always #5 clk = ~clk;

  im_stream_fetcher #(
    .MemAddrWidth (32),
    .MemDataWidth (64),
    .SlotWidth    (16),
    .ImAddrWidth  (10),
    .NumItemsWidth(16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clr_i          (clr),
    .start_i        (start),
    .cfg_base_addr_i(cfg_base),
    .cfg_num_items_i(cfg_num),
    .busy_o         (busy),
    .done_o         (done),
    .mem_req_o      (req),
    .mem_addr_o     (addr),
    .mem_gnt_i      (gnt),
    .mem_rvalid_i   (rvalid),
    .mem_rdata_i    (rdata),
    .lowdim_data_o  (ldata),
    .lowdim_valid_o (lvalid),
    .lowdim_ready_i (lready)
  );

  int checks = 0;
  int failures = 0;

  logic [9:0]  exp_items[$];
  logic [31:0] exp_addrs[$];
  logic [63:0] mem[logic [31:0]];

  int          gnt_stall = 0;
  int          bp_at = -1;
  int          bp_left = 0;
  int          job_hs = 0;
  int          rv_lat = 1;
  int          rv_cnt = 0;
  logic        rv_pend = 1'b0;
  logic [31:0] rv_addr = '0;
  int          done_seen = 0;
  int          gnt_seen = 0;
  int          cycle = 0;
  int          last_hs_cycle = 0;
  logic        consec_check = 1'b0;
  logic        req_stalled = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        lv_stalled = 1'b0;
  logic [9:0]  stalled_data = '0;
  logic        done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Memory responder, ready generator and output monitor, all at the falling edge.
  always @(negedge clk) begin
    cycle++;
    rvalid = 1'b0;
    if (rv_pend) begin
      rv_cnt--;
      if (rv_cnt <= 0) begin
        rvalid  = 1'b1;
        rdata   = mem.exists(rv_addr) ? mem[rv_addr] : '0;
        rv_pend = 1'b0;
      end
    end

    gnt = 1'b0;
    if (req) begin
      if (req_stalled) check("addr_stable", addr, prev_addr);
      if (gnt_stall > 0) begin
        gnt_stall--;
      end else begin
        gnt = 1'b1;
        gnt_seen++;
        if (exp_addrs.size() == 0) fail("unexpected_req");
        else check("req_addr", addr, exp_addrs.pop_front());
        rv_pend = 1'b1;
        rv_cnt  = rv_lat;
        rv_addr = addr;
      end
    end
    req_stalled = req && !gnt;
    prev_addr   = addr;

    lready = 1'b1;
    if (lvalid && job_hs == bp_at && bp_left > 0) begin
      lready = 1'b0;
      bp_left--;
    end
    if (lv_stalled) begin
      check("bp_valid", lvalid, 1);
      check("bp_data", ldata, stalled_data);
    end
    lv_stalled   = lvalid && !lready;
    stalled_data = ldata;

    if (lvalid && lready) begin
      if (exp_items.size() == 0) fail("unexpected_item");
      else check("item", ldata, exp_items.pop_front());
      if (consec_check && job_hs > 0) check("item_gap", cycle - last_hs_cycle, 1);
      last_hs_cycle = cycle;
      job_hs++;
    end

    if (done) begin
      done_seen++;
      if (done_prev) fail("done_width");
      check("busy_at_done", busy, 0);
    end
    done_prev = done;
  end

  task automatic start_job(input logic [31:0] base, input logic [15:0] n);
    job_hs = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    cfg_base = base;
    cfg_num  = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] base, input logic [15:0] n);
    int  d0;
    bit  seen;
    d0 = done_seen;
    start_job(base, n);
    check("req_cycle1", req, 1);
    check("busy_cycle1", busy, 1);
    check("addr_cycle1", addr, base);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("done_timeout");
    check("busy_after_done", busy, 0);
    @(posedge clk); #1;
    check("done_pulse_end", done, 0);
    check("done_count", done_seen - d0, 1);
    check("items_left", exp_items.size(), 0);
    check("addrs_left", exp_addrs.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    mem[32'h100] = 64'h0004_0003_0002_0001;
    mem[32'h108] = 64'h0008_0007_0006_0005;
    mem[32'h200] = 64'h0000_8401_0C00_FFFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", lvalid, 0);
    check("rst_data", ldata, 0);
    check("rst_addr", addr, 0);
    rst_n = 1'b1;

    // Basic job: one word, back-to-back items.
    exp_addrs.push_back(32'h100);
    for (int i = 1; i <= 4; i++) exp_items.push_back(10'(i));
    consec_check = 1'b1;
    run_job(32'h100, 16'd4);
    consec_check = 1'b0;

    // Word crossing: second word supplies items 5 and 6 from slots 0-1.
    exp_addrs.push_back(32'h100);
    exp_addrs.push_back(32'h108);
    for (int i = 1; i <= 6; i++) exp_items.push_back(10'(i));
    run_job(32'h100, 16'd6);

    // Backpressure while item 2 is presented.
    exp_addrs.push_back(32'h100);
    for (int i = 1; i <= 4; i++) exp_items.push_back(10'(i));
    bp_at   = 1;
    bp_left = 3;
    run_job(32'h100, 16'd4);
    check("bp_consumed", bp_left, 0);
    bp_at = -1;

    // Zero-item job: no request, done two cycles after start.
    d0 = done_seen;
    start_job(32'h300, 16'd0);
    check("zero_req_c1", req, 0);
    check("zero_done_c1", done, 0);
    check("zero_busy_c1", busy, 1);
    @(posedge clk); #1;
    check("zero_req_c2", req, 0);
    check("zero_done_c2", done, 1);
    check("zero_busy_c2", busy, 0);
    @(posedge clk); #1;
    check("zero_done_c3", done, 0);
    check("zero_done_count", done_seen - d0, 1);

    // Clear during WAIT; the read data then arrives late and must be ignored.
    exp_addrs.push_back(32'h100);
    rv_lat = 2;
    d0 = gnt_seen;
    start_job(32'h100, 16'd4);
    for (int i = 0; i < 20 && gnt_seen == d0; i++) begin
      @(posedge clk); #1;
    end
    check("clr_granted", gnt_seen - d0, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_req", req, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_valid", lvalid, 0);
    check("clr_data", ldata, 0);
    check("clr_addr", addr, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("late_valid", lvalid, 0);
      check("late_busy", busy, 0);
      check("late_data", ldata, 0);
    end
    rv_lat = 1;
    exp_addrs.push_back(32'h108);
    exp_items.push_back(10'd5);
    exp_items.push_back(10'd6);
    run_job(32'h108, 16'd2);

    // Grant stall with slot truncation to the item index width.
    gnt_stall = 5;
    exp_addrs.push_back(32'h200);
    exp_items.push_back(10'h3FF);
    exp_items.push_back(10'h000);
    exp_items.push_back(10'h001);
    run_job(32'h200, 16'd3);
    check("gnt_stall_consumed", gnt_stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_stream_fetcher.md
Name: im_stream_fetcher

Overview:
- Producer side of the item-memory input port: reads packed low-dimensional item indices from a word-addressed data memory and streams them one per handshake on a lowdim_data/valid/ready interface.
- Instantiated once per item-memory port (A and B) between the system data memory and the item memory top.
- Software-configured job: base address plus item count; start pulse in, done pulse out.

Parameters:
- MemAddrWidth, 32, byte address width of the data memory port.
- MemDataWidth, 64, data memory word width; must be a multiple of SlotWidth.
- SlotWidth, 16, width of one packed item slot inside a memory word.
- ImAddrWidth, 10, item index width; must be <= SlotWidth; the low ImAddrWidth bits of each slot are used.
- NumItemsWidth, 16, width of the item count configuration.
- SlotsPerWord, MemDataWidth/SlotWidth, derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- clr_i  in  1  synchronous soft clear
- start_i  in  1  job start pulse
- cfg_base_addr_i  in  MemAddrWidth  byte address of first word; word aligned
- cfg_num_items_i  in  NumItemsWidth  number of items to stream
- busy_o  out  1  high from an accepted start until done_o
- done_o  out  1  one-cycle pulse at job end
- mem_req_o  out  1  read request
- mem_addr_o  out  MemAddrWidth  read byte address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  MemDataWidth  read data
- lowdim_data_o  out  ImAddrWidth  item index towards item memory
- lowdim_valid_o  out  1  item valid
- lowdim_ready_i  in  1  item memory ready

Behaviour:
- Reset (rst_ni low at a clock edge) and clr_i: state IDLE, all counters and the word buffer zero, all outputs 0. clr_i takes priority over every other input. A late mem_rvalid_i after clear is ignored.
- FSM states: IDLE, REQ, WAIT, STREAM, DONE.
- IDLE:
  - start_i=1 latches the config, sets the word address to cfg_base_addr_i, item_cnt=0, slot_idx=0.
  - Next state is REQ, or DONE if cfg_num_items_i=0. A zero-item job issues no memory request.
- REQ: mem_req_o=1 with a stable mem_addr_o until mem_gnt_i. On the grant cycle go to WAIT.
- WAIT: on mem_rvalid_i, latch mem_rdata_i into the word buffer and go to STREAM.
- STREAM:
  - lowdim_valid_o=1.
  - lowdim_data_o = buffer[slot_idx*SlotWidth +: ImAddrWidth]. It is stable while valid and not ready.
  - A handshake is valid && ready. On each handshake, item_cnt and slot_idx increment.
  - If item_cnt+1 equals num_items, go to DONE.
  - Otherwise, if slot_idx is SlotsPerWord-1: slot_idx=0, word address += MemDataWidth/8, go to REQ.
  - Valid is never withdrawn without a handshake.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o is 1 in REQ, WAIT, STREAM and DONE. start_i is ignored while busy_o=1.
- Timing:
  - start at cycle 0 gives mem_req_o at cycle 1.
  - Grant at cycle 1 and rvalid at cycle 2 give lowdim_valid_o at cycle 3.
  - Throughput is one item per cycle within a word. There is at least a 2-cycle bubble at each word boundary: a single outstanding request, no prefetch.
- Address arithmetic wraps modulo 2^MemAddrWidth. Item counting is unsigned, full range; cfg_num_items_i = 2^NumItemsWidth-1 is legal.
- Partial last word: unused slots are discarded and no further request is issued.

Decomposition:
- Shared package hypercorex_fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT, STREAM, DONE).
  - SlotWidth default constant.
- Slot selection reuses the existing mux module (NumSel = SlotsPerWord, DataWidth = SlotWidth), with truncation to ImAddrWidth in this block.
- No other sub-module. The counters and FSM live in this block.

Test Plan:
- Basic job:
  - Stimulus: base=0x100, num_items=4, word=0x0004_0003_0002_0001, ready tied 1.
  - Required: one request at 0x100; data 1,2,3,4 on consecutive cycles; done_o pulses once; busy_o drops after done.
- Word crossing:
  - Stimulus: num_items=6.
  - Required: requests at 0x100 then 0x108; items 5 and 6 come from slots 0-1 of the second word; slots 2-3 are unused; no third request.
- Backpressure:
  - Stimulus: ready low for 3 cycles while item 2 is presented.
  - Required: valid stays 1 and data stays 2; no skipped or duplicated items.
- Zero items:
  - Stimulus: num_items=0.
  - Required: mem_req_o stays 0; done_o pulses 2 cycles after start.
- Clear mid-job:
  - Stimulus: clr_i during WAIT, then mem_rvalid_i arrives.
  - Required: IDLE, all outputs 0, the late data is ignored, and a new start runs correctly.
- Grant stall and truncation:
  - Stimulus: mem_gnt_i held low 5 cycles; slot value 0xFFFF with ImAddrWidth=10.
  - Required: mem_addr_o stable across the stall; lowdim_data_o=0x3FF.
